// File: rtl/pipe_pkg.sv
// Shared definitions for inter-stage pipeline registers: control decode type,
// per-boundary NOP payloads, stall-vector indices and an occupancy popcount.
package pipe_pkg;

  localparam int MAX_DEPTH = 4;

  typedef enum logic [1:0] {
    PIPE_ADV   = 2'd0,
    PIPE_BUB   = 2'd1,
    PIPE_HOLD  = 2'd2,
    PIPE_FLUSH = 2'd3
  } pipe_ctl_e;

  // Payload widths and empty-slot payloads per stage boundary.
  localparam int IFID_W  = 32 * 2;
  localparam int IDEX_W  = 32 * 3 + 16;
  localparam int EXMEM_W = 32 * 2 + 8;
  localparam int MEMWB_W = 32 + 8;

  localparam logic [IFID_W-1:0]  NOP_IFID  = '0;
  localparam logic [IDEX_W-1:0]  NOP_IDEX  = '0;
  localparam logic [EXMEM_W-1:0] NOP_EXMEM = '0;
  localparam logic [MEMWB_W-1:0] NOP_MEMWB = '0;

  // Bit positions in the core-wide stall vector.
  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;
  localparam int STALL_W   = 6;

  function automatic logic [2:0] popcount(input logic [MAX_DEPTH-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < MAX_DEPTH; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Stall/flush control plus upstream and downstream payload bus of one stage register.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 32 * 3 + 16,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = 16
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic              stall_up;
  logic              stall_dn;
  logic              flush;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [OCC_W-1:0]  occupancy;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output stall_up, stall_dn, flush, in_valid, in_data,
    input  out_valid, out_data, occupancy, bubble_cnt
  );

  modport slave (
    input  stall_up, stall_dn, flush, in_valid, in_data,
    output out_valid, out_data, occupancy, bubble_cnt
  );
endinterface

// File: rtl/pipe_stage_reg_ctl_dec.sv
// Collapses reset, flush and the two stall inputs into one per-cycle action.
module pipe_ctl_dec
  import pipe_pkg::*;
(
  input  logic      rst,
  input  logic      flush,
  input  logic      stall_up,
  input  logic      stall_dn,
  output pipe_ctl_e ctl
);
  always_comb begin
    ctl = PIPE_ADV;
    if (rst || flush) ctl = PIPE_FLUSH;
    else if (stall_dn) ctl = PIPE_HOLD;
    else if (stall_up) ctl = PIPE_BUB;
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised retiming register between two pipeline stages with hold,
// bubble insertion, flush, occupancy and a saturating bubble counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = 32 * 3 + 16,
  parameter int                DEPTH     = 1,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  parameter int                CNT_W     = 16
) (
  input logic              clk,
  input logic              rst,
  pipe_stage_reg_if.slave  bus
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
    $error("pipe_stage_reg: DEPTH=%0d outside 1..%0d", DEPTH, MAX_DEPTH);
  end
  if (DATA_W < 1) begin : g_bad_width
    $error("pipe_stage_reg: DATA_W=%0d must be >= 1", DATA_W);
  end

  pipe_ctl_e ctl;

  pipe_ctl_dec u_dec (
    .rst      (rst),
    .flush    (bus.flush),
    .stall_up (bus.stall_up),
    .stall_dn (bus.stall_dn),
    .ctl      (ctl)
  );

  logic [DEPTH-1:0]  vld_vec;
  logic [DATA_W-1:0] data_vec [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    logic              vld_q, vld_d, src_vld;
    logic [DATA_W-1:0] data_q, data_d, src_data;

    if (k == 0) begin : g_head
      // A bubble and an invalid input both load an empty slot.
      assign src_vld  = (ctl == PIPE_ADV) && bus.in_valid;
      assign src_data = src_vld ? bus.in_data : NOP_VALUE;
    end else begin : g_tail
      assign src_vld  = vld_vec[k-1];
      assign src_data = data_vec[k-1];
    end

    always_comb begin
      vld_d  = vld_q;
      data_d = data_q;
      case (ctl)
        PIPE_FLUSH: begin
          vld_d  = 1'b0;
          data_d = NOP_VALUE;
        end
        PIPE_ADV, PIPE_BUB: begin
          vld_d  = src_vld;
          data_d = src_data;
        end
        default: ;
      endcase
    end

    always_ff @(posedge clk) begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end

    assign vld_vec[k]  = vld_q;
    assign data_vec[k] = data_q;
  end

  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (rst) bubble_cnt_d = '0;
    else if (ctl == PIPE_BUB && !(&bubble_cnt_q)) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) bubble_cnt_q <= bubble_cnt_d;

  logic [MAX_DEPTH-1:0] vld_ext;

  always_comb begin
    vld_ext = '0;
    vld_ext[DEPTH-1:0] = vld_vec;
  end

  assign bus.out_valid  = vld_vec[DEPTH-1];
  assign bus.out_data   = data_vec[DEPTH-1];
  assign bus.occupancy  = OCC_W'(popcount(vld_ext));
  assign bus.bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: three configurations share one stimulus stream
// and are compared every cycle against a slot-list model, plus literal checkpoints.
module tb_pipe_stage_reg;
  localparam int          DW  = 16;
  localparam logic [15:0] NOP = 16'hF00D;
  localparam int          NI  = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0, stall_up = 1'b0, stall_dn = 1'b0, in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(DW), .DEPTH(1), .CNT_W(16)) b1 ();
  pipe_stage_reg_if #(.DATA_W(DW), .DEPTH(2), .CNT_W(16)) b2 ();
  pipe_stage_reg_if #(.DATA_W(DW), .DEPTH(2), .CNT_W(2))  b3 ();

  assign b1.stall_up = stall_up; assign b1.stall_dn = stall_dn; assign b1.flush = flush;
  assign b1.in_valid = in_valid; assign b1.in_data  = in_data;
  assign b2.stall_up = stall_up; assign b2.stall_dn = stall_dn; assign b2.flush = flush;
  assign b2.in_valid = in_valid; assign b2.in_data  = in_data;
  assign b3.stall_up = stall_up; assign b3.stall_dn = stall_dn; assign b3.flush = flush;
  assign b3.in_valid = in_valid; assign b3.in_data  = in_data;

  pipe_stage_reg #(.DATA_W(DW), .DEPTH(1), .NOP_VALUE(NOP), .CNT_W(16)) u_d1 (.clk(clk), .rst(rst), .bus(b1));
  pipe_stage_reg #(.DATA_W(DW), .DEPTH(2), .NOP_VALUE(NOP), .CNT_W(16)) u_d2 (.clk(clk), .rst(rst), .bus(b2));
  pipe_stage_reg #(.DATA_W(DW), .DEPTH(2), .NOP_VALUE(NOP), .CNT_W(2))  u_d3 (.clk(clk), .rst(rst), .bus(b3));

  logic          ov [NI];
  logic [DW-1:0] od [NI];
  int            oc [NI];
  int            ob [NI];
  assign ov[0] = b1.out_valid; assign od[0] = b1.out_data;
  assign oc[0] = int'(b1.occupancy); assign ob[0] = int'(b1.bubble_cnt);
  assign ov[1] = b2.out_valid; assign od[1] = b2.out_data;
  assign oc[1] = int'(b2.occupancy); assign ob[1] = int'(b2.bubble_cnt);
  assign ov[2] = b3.out_valid; assign od[2] = b3.out_data;
  assign oc[2] = int'(b3.occupancy); assign ob[2] = int'(b3.bubble_cnt);

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each instance is a list of slots; index 0 is newest, dep-1 is the output.
  int          dep  [NI] = '{1, 2, 2};
  int          cmax [NI] = '{65535, 65535, 3};
  bit          mv   [NI][4];
  logic [15:0] md   [NI][4];
  int          mb   [NI];

  initial begin
    for (int i = 0; i < NI; i++) begin
      mb[i] = 0;
      for (int k = 0; k < 4; k++) begin mv[i][k] = 1'b0; md[i][k] = NOP; end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst || flush) begin
        for (int k = 0; k < 4; k++) begin mv[i][k] <= 1'b0; md[i][k] <= NOP; end
      end else if (!stall_dn) begin
        for (int k = 1; k < 4; k++) begin mv[i][k] <= mv[i][k-1]; md[i][k] <= md[i][k-1]; end
        if (stall_up) begin
          mv[i][0] <= 1'b0; md[i][0] <= NOP;
        end else begin
          mv[i][0] <= in_valid; md[i][0] <= in_valid ? in_data : NOP;
        end
      end
      if (rst) mb[i] <= 0;
      else if (!flush && !stall_dn && stall_up && mb[i] < cmax[i]) mb[i] <= mb[i] + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        int occ;
        occ = 0;
        for (int k = 0; k < dep[i]; k++) occ += int'(mv[i][k]);
        chk($sformatf("d%0d.out_valid", i), 32'(ov[i]), 32'(mv[i][dep[i]-1]));
        chk($sformatf("d%0d.out_data", i), 32'(od[i]), 32'(md[i][dep[i]-1]));
        chk($sformatf("d%0d.occupancy", i), oc[i], occ);
        chk($sformatf("d%0d.bubble_cnt", i), ob[i], mb[i]);
      end
    end
  end

  task automatic step(input logic r, input logic f, input logic su, input logic sd,
                      input logic iv, input logic [15:0] id);
    rst = r; flush = f; stall_up = su; stall_dn = sd; in_valid = iv; in_data = id;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    // Reset with valid input present.
    for (int c = 0; c < 2; c++) begin
      step(1, 0, 0, 0, 1, 16'h0ABC);
      chk_en = 1'b1;
      chk("rst.out_valid", 32'(b2.out_valid), 0);
      chk("rst.out_data", 32'(b2.out_data), 32'(NOP));
      chk("rst.occupancy", 32'(b2.occupancy), 0);
      chk("rst.bubble_cnt", 32'(b2.bubble_cnt), 0);
    end

    // Straight-through flow, DEPTH=2 latency 2, DEPTH=1 latency 1.
    step(0, 0, 0, 0, 1, 16'd1);
    chk("adv1.d2.out_valid", 32'(b2.out_valid), 0);
    chk("adv1.d1.out_data", 32'(b1.out_data), 1);
    step(0, 0, 0, 0, 1, 16'd2);
    chk("adv2.d2.out_data", 32'(b2.out_data), 1);
    chk("adv2.d2.occupancy", 32'(b2.occupancy), 2);
    step(0, 0, 0, 0, 1, 16'd3);
    chk("adv3.d2.out_data", 32'(b2.out_data), 2);
    step(0, 0, 0, 0, 1, 16'd4);
    chk("adv4.d2.out_data", 32'(b2.out_data), 3);

    // Downstream hold for 4 cycles; stall_up during hold must not count a bubble.
    for (int c = 0; c < 4; c++) begin
      step(0, 0, (c == 2), 1, 1, 16'h0011 + 16'(c));
      chk("hold.d2.out_data", 32'(b2.out_data), 3);
      chk("hold.d1.out_data", 32'(b1.out_data), 4);
      chk("hold.d2.bubble_cnt", 32'(b2.bubble_cnt), 0);
    end
    step(0, 0, 0, 0, 1, 16'd5);
    chk("release.d2.out_data", 32'(b2.out_data), 4);

    // Flush beats hold.
    step(0, 1, 0, 1, 1, 16'h0077);
    chk("flush_hold.d2.occupancy", 32'(b2.occupancy), 0);
    chk("flush_hold.d2.out_valid", 32'(b2.out_valid), 0);
    chk("flush_hold.d2.out_data", 32'(b2.out_data), 32'(NOP));
    chk("flush_hold.d2.bubble_cnt", 32'(b2.bubble_cnt), 0);

    // Bubbles: three, then two more to saturate the 2-bit counter.
    for (int c = 0; c < 3; c++) step(0, 0, 1, 0, 1, 16'h0050 + 16'(c));
    chk("bub3.d1.out_valid", 32'(b1.out_valid), 0);
    chk("bub3.d1.out_data", 32'(b1.out_data), 32'(NOP));
    chk("bub3.d1.bubble_cnt", 32'(b1.bubble_cnt), 3);
    chk("bub3.d3.bubble_cnt", 32'(b3.bubble_cnt), 3);
    step(0, 0, 1, 0, 1, 16'h0060);
    step(0, 0, 1, 0, 1, 16'h0061);
    chk("bub5.d3.bubble_cnt", 32'(b3.bubble_cnt), 3);
    chk("bub5.d2.bubble_cnt", 32'(b2.bubble_cnt), 5);

    // Empty advance is not a bubble.
    step(0, 0, 0, 0, 0, 16'h0099);
    chk("empty_adv.d2.bubble_cnt", 32'(b2.bubble_cnt), 5);
    chk("empty_adv.d1.out_data", 32'(b1.out_data), 32'(NOP));
    step(0, 0, 0, 0, 1, 16'd6);
    step(0, 0, 0, 0, 1, 16'd7);
    chk("refill.d2.out_data", 32'(b2.out_data), 6);
    chk("refill.d2.occupancy", 32'(b2.occupancy), 2);

    // Flush with stall_up: flush wins, counter untouched.
    step(0, 1, 1, 0, 1, 16'h0088);
    chk("flush_bub.d2.bubble_cnt", 32'(b2.bubble_cnt), 5);
    chk("flush_bub.d2.occupancy", 32'(b2.occupancy), 0);

    // Flush with reset clears everything including the counter.
    step(0, 0, 0, 0, 1, 16'd8);
    step(1, 1, 0, 0, 1, 16'd9);
    chk("rst_flush.d2.bubble_cnt", 32'(b2.bubble_cnt), 0);
    chk("rst_flush.d3.bubble_cnt", 32'(b3.bubble_cnt), 0);
    chk("rst_flush.d1.out_valid", 32'(b1.out_valid), 0);
    step(0, 0, 0, 0, 1, 16'h00A0);
    step(0, 0, 0, 0, 1, 16'h00A1);
    chk("post_rst.d2.out_data", 32'(b2.out_data), 32'h00A0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
